data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Multi-cycle data-memory responder on the MEM-stage side of the EX/MEM register.
//   - Serves the MemRead/MemWrite requests that register issues.
//   - Holds the pipeline via mem_stall while an access is in flight.
//   - Presents read data to the MEM/WB register on completion.
//   - Word-addressed storage with a programmable access latency.
// PARAMETERS
//   ADDR_WIDTH  8   log2 of word entries (256 x 32-bit words)
//   LATENCY     2   extra busy cycles per access; legal range 1..15
// PORTS
//   clk            in   1   single clock, rising edge
//   reset          in   1   asynchronous, active-low reset
//   mem_read       in   1   read request (EX/MEM MemRead_out)
//   mem_write      in   1   write request (EX/MEM MemWrite_out)
//   addr           in   32  byte address (EX/MEM ALU_result_out)
//   write_data     in   32  store data (EX/MEM reg_read_data_2_out)
//   read_data      out  32  load data to MEM/WB
//   read_valid     out  1   one-cycle pulse: read_data updated by a completed read
//   mem_stall      out  1   hold IF/ID, ID/EX and EX/MEM; freeze PC
//   access_err     out  1   one-cycle pulse: misaligned addr, or read+write together
// BEHAVIOUR
//   Reset (reset=0, async)
//   - state=IDLE; read_data=0, read_valid=0, access_err=0, latch regs and count cleared.
//   - mem_stall drops immediately.
//   - Array contents are not reset; simulation initialises them to 0.
//   - Reset mid-access aborts the access; a pending write is never committed.
//   Addressing and width
//   - Word index = addr[ADDR_WIDTH+1:2]; higher bits are ignored (alias/wrap).
//   - addr[1:0]!=0: access proceeds on the truncated word and access_err pulses in DONE.
//   FSM: IDLE -> BUSY -> DONE -> IDLE
//   - IDLE, req=mem_read|mem_write:
//       mem_stall=1 (combinational from req).
//       Latch addr, write_data and op; count=LATENCY-1; next state BUSY.
//   - IDLE, no req: stall=0; stay IDLE.
//   - BUSY: mem_stall=1; count decrements each cycle.
//       At count==0, commit the access on that edge (write array, or load read_data); next state DONE.
//   - DONE: mem_stall=0, read_valid=1 for reads.
//       Pipeline registers advance on this edge; MEM/WB captures read_data.
//       Request inputs are ignored in DONE (they still show the old op); next state IDLE.
//   Timing
//   - Request first visible at cycle t: stall high for cycles t..t+LATENCY (LATENCY+1 cycles).
//   - DONE at t+LATENCY+1; read_data valid from DONE and held until the next read commits.
//   - Writes never change read_data or pulse read_valid.
//   Simultaneous and boundary cases
//   - mem_read&mem_write: treated as a write; access_err pulses in DONE.
//   - Back-to-back requests: next request is accepted in the IDLE cycle after DONE.
//       No request is lost; there is exactly one access per DONE.
//   - Inputs changing during BUSY have no effect (latched copy is used).
//   - Read of an address written by the immediately preceding access returns the new data.
// TESTING
//   1 LATENCY=2: write 0xDEADBEEF to addr 0x10 at t=0 -> stall high t0..t2, DONE t3, no read_valid.
//     Then read 0x10 -> read_data=0xDEADBEEF with read_valid at DONE.
//   2 Read addr 0x3FC then 0x7FC (ADDR_WIDTH=8) -> both hit word 255; alias returns the same data.
//   3 Write to addr 0x22 -> word 8 written, access_err=1 for one cycle in DONE; read 0x20 returns the data.
//   4 mem_read=mem_write=1, addr 0x40, data 0x5 -> write performed, access_err pulse.
//     Subsequent read of 0x40 returns 0x5.
//   5 Write 0x1234 to addr 0x80; reset low during BUSY -> stall=0 at once, state IDLE.
//     Later read of 0x80 returns the old value (0).
//   6 Back-to-back write 0xA at 0x0, then read 0x0, with requests held high continuously ->
//     two DONE pulses 4 cycles apart (LATENCY=2); read returns 0xA.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Bus between the EX/MEM pipeline register (master) and the MEM-stage data
// memory responder (slave).
//   mem_read/mem_write : request strobes from EX/MEM (MemRead/MemWrite)
//   addr               : byte address (ALU result)
//   write_data         : store data (reg_read_data_2)
//   read_data          : load data toward MEM/WB
//   read_valid         : one-cycle pulse, read_data refreshed by a completed read
//   mem_stall          : freeze PC and IF/ID, ID/EX, EX/MEM while busy
//   access_err         : one-cycle pulse, misaligned or read+write together
interface data_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_valid;
  logic        mem_stall;
  logic        access_err;

  modport master (
    output mem_read, mem_write, addr, write_data,
    input  read_data, read_valid, mem_stall, access_err
  );

  modport slave (
    input  mem_read, mem_write, addr, write_data,
    output read_data, read_valid, mem_stall, access_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
// Word-addressed 2**ADDR_WIDTH x 32 storage with LATENCY busy cycles per access
// (legal LATENCY 1..15). FSM IDLE -> BUSY -> DONE -> IDLE; the access commits
// on the edge leaving the last BUSY cycle, so DONE sees the result.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : data_mem_responder_if.slave (request in, response/stall out)
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                r_state;
  logic [3:0]            r_count;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic                  r_is_write;
  logic                  r_err;
  logic [31:0]           r_read_data;
  logic                  r_read_valid;
  logic                  r_access_err;
  logic [31:0]           r_mem [2**ADDR_WIDTH];

  logic w_req;
  logic w_commit;
  logic w_unused;

  assign w_req    = bus.mem_read | bus.mem_write;
  assign w_commit = (r_state == BUSY) && (r_count == 4'd0);
  // Address bits above the word index alias onto the same entry.
  assign w_unused = ^bus.addr[31:ADDR_WIDTH+2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_is_write   <= 1'b0;
      r_err        <= 1'b0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_access_err <= 1'b0;
    end else begin
      r_read_valid <= 1'b0;
      r_access_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_idx      <= bus.addr[ADDR_WIDTH+1:2];
            r_wdata    <= bus.write_data;
            // Read+write together is served as a write and flagged.
            r_is_write <= bus.mem_write;
            r_err      <= (bus.addr[1:0] != 2'b00) | (bus.mem_read & bus.mem_write);
            r_count    <= LAT_M1;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (r_count == 4'd0) begin
            if (!r_is_write) begin
              r_read_data  <= r_mem[r_idx];
              r_read_valid <= 1'b1;
            end
            r_access_err <= r_err;
            r_state      <= DONE;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        // Requests still show the old op here; ignore them.
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage is not reset. Reset forces IDLE asynchronously, so a write still
  // pending in BUSY never reaches this commit.
  always_ff @(posedge clk) begin
    if (w_commit && r_is_write) r_mem[r_idx] <= r_wdata;
  end

  // Stall is raised combinationally in the request cycle so the pipeline
  // freezes immediately; reset drops it at once.
  assign bus.mem_stall  = reset & (((r_state == IDLE) & w_req) | (r_state == BUSY));
  assign bus.read_data  = r_read_data;
  assign bus.read_valid = r_read_valid;
  assign bus.access_err = r_access_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (ADDR_WIDTH=8, LATENCY=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_data_mem_responder;
  localparam int LAT = 2;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  logic [31:0] last_rd;

  data_mem_responder_if bus ();

  data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete access starting in an IDLE cycle; inputs are scrambled
  // during BUSY to show the latched copy is used.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err,
                        input logic [31:0] exp_rd, input string tag);
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.addr       = a;
    bus.write_data = d;
    @(negedge clk);
    chk({tag, ".stall_req"}, 32'(bus.mem_stall), 32'd1);
    @(posedge clk); #1;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.addr       = ~a;
    bus.write_data = ~d;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      chk({tag, ".stall_busy"}, 32'(bus.mem_stall), 32'd1);
    end
    @(negedge clk);
    chk({tag, ".stall_done"}, 32'(bus.mem_stall), 32'd0);
    chk({tag, ".valid_done"}, 32'(bus.read_valid), 32'(rd & ~wr));
    chk({tag, ".err_done"}, 32'(bus.access_err), 32'(exp_err));
    chk({tag, ".rdata"}, bus.read_data, exp_rd);
    @(negedge clk);
    chk({tag, ".valid_after"}, 32'(bus.read_valid), 32'd0);
    chk({tag, ".err_after"}, 32'(bus.access_err), 32'd0);
    chk({tag, ".stall_after"}, 32'(bus.mem_stall), 32'd0);
    last_rd = exp_rd;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] exp_stall;
    logic [7:0] exp_valid;
    n_chk   = 0;
    n_fail  = 0;
    last_rd = 32'd0;
    reset          = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b1;   // request during reset must not stall
    bus.addr       = 32'h10;
    bus.write_data = 32'h1;

    repeat (2) @(negedge clk);
    chk("rst.stall", 32'(bus.mem_stall), 32'd0);
    chk("rst.valid", 32'(bus.read_valid), 32'd0);
    chk("rst.err", 32'(bus.access_err), 32'd0);
    chk("rst.rdata", bus.read_data, 32'd0);
    bus.mem_write = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: write then read back
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, last_rd, "t1.wr");
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "t1.rd");

    // 2: aliasing of higher address bits onto word 255
    access(1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0, last_rd, "t2.wr");
    access(1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hCAFEF00D, "t2.rd");
    access(1'b1, 1'b0, 32'h7FC, 32'h0, 1'b0, 32'hCAFEF00D, "t2.alias");

    // 3: misaligned write lands on word 8 and flags an error
    access(1'b0, 1'b1, 32'h22, 32'h13579BDF, 1'b1, last_rd, "t3.wr");
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h13579BDF, "t3.rd");
    access(1'b1, 1'b0, 32'h23, 32'h0, 1'b1, 32'h13579BDF, "t3.rdmis");

    // 4: read+write together is a write with an error pulse
    access(1'b1, 1'b1, 32'h40, 32'h5, 1'b1, last_rd, "t4.rw");
    access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h5, "t4.rd");

    // 5: reset during BUSY aborts the write
    access(1'b0, 1'b1, 32'h80, 32'h0, 1'b0, last_rd, "t5.init");
    bus.mem_write  = 1'b1;
    bus.addr       = 32'h80;
    bus.write_data = 32'h1234;
    @(negedge clk);
    chk("t5.stall_req", 32'(bus.mem_stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5.stall_rst", 32'(bus.mem_stall), 32'd0);
    chk("t5.rdata_rst", bus.read_data, 32'd0);
    chk("t5.valid_rst", 32'(bus.read_valid), 32'd0);
    @(negedge clk);
    bus.mem_write = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    last_rd = 32'd0;
    access(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0, "t5.rd");

    // 6: back-to-back write then read, requests held continuously
    exp_stall = 8'b0111_0111;
    exp_valid = 8'b1000_0000;
    bus.mem_write  = 1'b1;
    bus.addr       = 32'h0;
    bus.write_data = 32'hA;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t6.stall%0d", i), 32'(bus.mem_stall), 32'(exp_stall[i]));
      chk($sformatf("t6.valid%0d", i), 32'(bus.read_valid), 32'(exp_valid[i]));
      if (i == 7) chk("t6.rdata", bus.read_data, 32'hA);
      @(posedge clk); #1;
      if (i == 3) begin
        bus.mem_write  = 1'b0;
        bus.mem_read   = 1'b1;
        bus.write_data = 32'h0;
      end
      if (i == 7) bus.mem_read = 1'b0;
    end
    @(negedge clk);
    chk("t6.stall_end", 32'(bus.mem_stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
